// File: rtl/axi_lite_master_ctrl_if.sv
// AXI-Lite bus bundle between the command controller (master)
// and an AXI-Lite slave.
interface axi_lite_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI-Lite master: one command in, one
// AXI-Lite read or write out, one response back.
module axi_lite_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout,
  axi_lite_master_ctrl_if.master bus
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RD, RDATA, RSP
  } state_t;

  state_t state_q, state_n;

  logic                  cmd_ready_q, cmd_ready_n;
  logic                  awvalid_q, awvalid_n;
  logic                  wvalid_q, wvalid_n;
  logic                  bready_q, bready_n;
  logic                  arvalid_q, arvalid_n;
  logic                  rready_q, rready_n;
  logic                  rsp_valid_q, rsp_valid_n;
  logic                  timeout_q, timeout_n;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_n;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0]            resp_q, resp_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  busy;
  logic                  aw_fin, w_fin;

  always_comb begin
    state_n     = state_q;
    cmd_ready_n = cmd_ready_q;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    bready_n    = bready_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    rsp_valid_n = rsp_valid_q;
    awaddr_n    = awaddr_q;
    araddr_n    = araddr_q;
    wdata_n     = wdata_q;
    rdata_n     = rdata_q;
    resp_n      = resp_q;
    cnt_n       = cnt_q;
    timeout_n   = 1'b0;
    aw_fin      = !awvalid_q || bus.AWREADY;
    w_fin       = !wvalid_q || bus.WREADY;
    busy        = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_n = 1'b0;
          cnt_n       = '0;
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD;
          end
        end
      end
      WR: begin
        busy = 1'b1;
        // AW and W retire independently
        awvalid_n = awvalid_q && !bus.AWREADY;
        wvalid_n  = wvalid_q && !bus.WREADY;
        if (aw_fin && w_fin) begin
          bready_n = 1'b1;
          state_n  = WRESP;
        end
      end
      WRESP: begin
        busy = 1'b1;
        if (bus.BVALID) begin
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          resp_n      = bus.BRESP;
          rdata_n     = '0;
          state_n     = RSP;
        end
      end
      RD: begin
        busy = 1'b1;
        if (bus.ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RDATA;
        end
      end
      RDATA: begin
        busy = 1'b1;
        if (bus.RVALID) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = bus.RDATA;
          resp_n      = 2'b00;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // saturating wait counter, pulse once on reaching the limit
    if (TIMEOUT != 0 && busy && cnt_q != TO) begin
      cnt_n     = cnt_q + CW'(1);
      timeout_n = (cnt_n == TO);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_n;
      cmd_ready_q <= cmd_ready_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      rsp_valid_q <= rsp_valid_n;
      timeout_q   <= timeout_n;
      awaddr_q    <= awaddr_n;
      araddr_q    <= araddr_n;
      wdata_q     <= wdata_n;
      rdata_q     <= rdata_n;
      resp_q      <= resp_n;
      cnt_q       <= cnt_n;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign timeout     = timeout_q;
  assign bus.AWADDR  = awaddr_q;
  assign bus.AWVALID = awvalid_q;
  assign bus.WDATA   = wdata_q;
  assign bus.WVALID  = wvalid_q;
  assign bus.BREADY  = bready_q;
  assign bus.ARADDR  = araddr_q;
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = rready_q;

endmodule
